// File: rtl/mem_arbiter.sv
// Two-port (CPU / loader) round-robin arbiter in front of a single-port RAM.
// Each transaction is IDLE -> ACCESS (WAIT_CYCLES) -> DONE (one READY pulse).
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CPU_CS,
    input  logic        CPU_WE,
    input  logic [15:0] CPU_ADDR,
    input  logic [15:0] CPU_DIN,
    output logic [15:0] CPU_DOUT,
    output logic        CPU_READY,
    input  logic        LDR_CS,
    input  logic        LDR_WE,
    input  logic [15:0] LDR_ADDR,
    input  logic [15:0] LDR_DIN,
    output logic [15:0] LDR_DOUT,
    output logic        LDR_READY,
    output logic        MEM_EN,
    output logic        MEM_WE,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] MEM_DIN,
    input  logic [15:0] MEM_DOUT,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        last_ldr;
    logic        gnt_ldr;
    logic        we_q;
    logic        pick_ldr;

    // Loader wins when alone, or on a tie when the CPU was granted last.
    always_comb begin
        pick_ldr = LDR_CS && (!CPU_CS || !last_ldr);
    end

    // Arbitration FSM with registered memory-side and handshake outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            last_ldr  <= 1'b1;
            gnt_ldr   <= 1'b0;
            we_q      <= 1'b0;
            MEM_EN    <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= 16'h0000;
            MEM_DIN   <= 16'h0000;
            CPU_DOUT  <= 16'h0000;
            LDR_DOUT  <= 16'h0000;
            CPU_READY <= 1'b0;
            LDR_READY <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            MEM_WE    <= 1'b0;
            CPU_READY <= 1'b0;
            LDR_READY <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (CPU_CS || LDR_CS) begin
                        gnt_ldr  <= pick_ldr;
                        last_ldr <= pick_ldr;
                        we_q     <= pick_ldr ? LDR_WE : CPU_WE;
                        MEM_WE   <= pick_ldr ? LDR_WE : CPU_WE;
                        MEM_ADDR <= pick_ldr ? LDR_ADDR : CPU_ADDR;
                        MEM_DIN  <= pick_ldr ? LDR_DIN : CPU_DIN;
                        MEM_EN   <= 1'b1;
                        cnt      <= 4'd0;
                        BUSY     <= 1'b1;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == LAST) begin
                        MEM_EN <= 1'b0;
                        state  <= DONE;
                        if (!we_q) begin
                            if (gnt_ldr) LDR_DOUT <= MEM_DOUT;
                            else         CPU_DOUT <= MEM_DOUT;
                        end
                        if (gnt_ldr) LDR_READY <= 1'b1;
                        else         CPU_READY <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with WAIT_CYCLES=2 and a behavioural RAM.
// Expected values are hand-computed from the transaction timing.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CPU_CS, CPU_WE, LDR_CS, LDR_WE;
    logic [15:0] CPU_ADDR, CPU_DIN, LDR_ADDR, LDR_DIN;
    logic [15:0] CPU_DOUT, LDR_DOUT;
    logic        CPU_READY, LDR_READY;
    logic        MEM_EN, MEM_WE, BUSY;
    logic [15:0] MEM_ADDR, MEM_DIN, MEM_DOUT;

    logic [15:0] ram [0:65535];

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter #(.WAIT_CYCLES(2)) dut (
        .CLK(CLK), .RST(RST),
        .CPU_CS(CPU_CS), .CPU_WE(CPU_WE),
        .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN),
        .CPU_DOUT(CPU_DOUT), .CPU_READY(CPU_READY),
        .LDR_CS(LDR_CS), .LDR_WE(LDR_WE),
        .LDR_ADDR(LDR_ADDR), .LDR_DIN(LDR_DIN),
        .LDR_DOUT(LDR_DOUT), .LDR_READY(LDR_READY),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE),
        .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
        .MEM_DOUT(MEM_DOUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Behavioural RAM: combinational read, write on the strobe.
    assign MEM_DOUT = ram[MEM_ADDR];
    always @(posedge CLK) begin
        if (MEM_EN && MEM_WE) ram[MEM_ADDR] <= MEM_DIN;
    end

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One transaction from an idle arbiter; CS drops right after the grant.
    task automatic txn(input bit ldr, input bit we,
                       input logic [15:0] a, input logic [15:0] d,
                       output int lat, output int en_n, output int we_n);
        lat = -1;
        en_n = 0;
        we_n = 0;
        if (ldr) begin
            LDR_WE = we; LDR_ADDR = a; LDR_DIN = d; LDR_CS = 1'b1;
        end else begin
            CPU_WE = we; CPU_ADDR = a; CPU_DIN = d; CPU_CS = 1'b1;
        end
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (MEM_EN) en_n++;
            if (MEM_WE) we_n++;
            if (i == 1) begin
                CPU_CS = 1'b0;
                LDR_CS = 1'b0;
            end
            if (ldr ? LDR_READY : CPU_READY) begin
                lat = i;
                break;
            end
        end
        tick();
    endtask

    // Both ports request together; records the READY cycle of each.
    task automatic tie(output int cr, output int lr);
        cr = -1;
        lr = -1;
        CPU_WE = 1'b0; CPU_ADDR = 16'h3000;
        LDR_WE = 1'b0; LDR_ADDR = 16'h3001;
        CPU_CS = 1'b1;
        LDR_CS = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (CPU_READY && cr < 0) begin
                cr = i;
                CPU_CS = 1'b0;
            end
            if (LDR_READY && lr < 0) begin
                lr = i;
                LDR_CS = 1'b0;
            end
            if (cr >= 0 && lr >= 0) break;
        end
        CPU_CS = 1'b0;
        LDR_CS = 1'b0;
        tick();
    endtask

    int lat, en_n, we_n, cr, lr, r1, r2, bl;
    logic seen;

    initial begin
        RST = 1'b1;
        CPU_CS = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_DIN = '0;
        LDR_CS = 1'b0; LDR_WE = 1'b0; LDR_ADDR = '0; LDR_DIN = '0;
        tick();
        tick();
        chk("rst_flags",
            16'({MEM_EN, MEM_WE, BUSY, CPU_READY, LDR_READY}), 16'h0);
        chk("rst_addr", MEM_ADDR, 16'h0000);
        chk("rst_din", MEM_DIN, 16'h0000);
        chk("rst_cdout", CPU_DOUT, 16'h0000);
        chk("rst_ldout", LDR_DOUT, 16'h0000);
        RST = 1'b0;
        tick();

        // Loader preloads RAM.
        txn(1'b1, 1'b1, 16'h3000, 16'h1234, lat, en_n, we_n);
        chk("ldr_wr_lat", 16'(lat), 16'd3);
        chk("ldr_wr_we", 16'(we_n), 16'd1);
        txn(1'b1, 1'b1, 16'h4000, 16'h5555, lat, en_n, we_n);
        chk("ldr_wr2_lat", 16'(lat), 16'd3);

        // CPU read.
        txn(1'b0, 1'b0, 16'h3000, 16'h0000, lat, en_n, we_n);
        chk("rd_lat", 16'(lat), 16'd3);
        chk("rd_en", 16'(en_n), 16'd2);
        chk("rd_we", 16'(we_n), 16'd0);
        chk("rd_dout", CPU_DOUT, 16'h1234);
        chk("rd_ldout", LDR_DOUT, 16'h0000);
        chk("rd_busy", 16'(BUSY), 16'h0);

        // CPU write then read back.
        txn(1'b0, 1'b1, 16'h3001, 16'hBEEF, lat, en_n, we_n);
        chk("wr_lat", 16'(lat), 16'd3);
        chk("wr_we", 16'(we_n), 16'd1);
        chk("wr_en", 16'(en_n), 16'd2);
        chk("wr_dout_hold", CPU_DOUT, 16'h1234);
        txn(1'b0, 1'b0, 16'h3001, 16'h0000, lat, en_n, we_n);
        chk("rb_dout", CPU_DOUT, 16'hBEEF);

        // Inputs change after the grant.
        CPU_WE = 1'b0; CPU_ADDR = 16'h3000; CPU_CS = 1'b1;
        tick();
        chk("chg_addr0", MEM_ADDR, 16'h3000);
        CPU_ADDR = 16'h4000; CPU_WE = 1'b1; CPU_DIN = 16'hDEAD;
        CPU_CS = 1'b0;
        tick();
        chk("chg_addr1", MEM_ADDR, 16'h3000);
        chk("chg_we", 16'(MEM_WE), 16'h0);
        tick();
        chk("chg_rdy", 16'(CPU_READY), 16'h1);
        chk("chg_dout", CPU_DOUT, 16'h1234);
        tick();
        chk("chg_ram", ram[16'h4000], 16'h5555);

        // Reset in the 2nd ACCESS cycle of a read.
        CPU_WE = 1'b0; CPU_ADDR = 16'h4000; CPU_CS = 1'b1;
        tick();
        CPU_CS = 1'b0;
        tick();
        chk("mr_en", 16'(MEM_EN), 16'h1);
        RST = 1'b1;
        #1;
        chk("mr_flags",
            16'({MEM_EN, MEM_WE, BUSY, CPU_READY, LDR_READY}), 16'h0);
        chk("mr_cdout", CPU_DOUT, 16'h0000);
        chk("mr_addr", MEM_ADDR, 16'h0000);
        tick();
        RST = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | CPU_READY | LDR_READY | BUSY;
        end
        chk("mr_quiet", 16'(seen), 16'h0);
        txn(1'b0, 1'b0, 16'h4000, 16'h0000, lat, en_n, we_n);
        chk("mr_next_lat", 16'(lat), 16'd3);
        chk("mr_next_dout", CPU_DOUT, 16'h5555);

        // Tie right after reset: CPU first.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        tie(cr, lr);
        chk("tie1_cpu", 16'(cr), 16'd3);
        chk("tie1_ldr", 16'(lr), 16'd7);
        chk("tie1_cdout", CPU_DOUT, 16'h1234);
        chk("tie1_ldout", LDR_DOUT, 16'hBEEF);

        // After a CPU grant, a tie goes to the loader.
        txn(1'b0, 1'b0, 16'h4000, 16'h0000, lat, en_n, we_n);
        tie(cr, lr);
        chk("tie2_ldr", 16'(lr), 16'd3);
        chk("tie2_cpu", 16'(cr), 16'd7);

        // CS held across two transactions.
        CPU_WE = 1'b0; CPU_ADDR = 16'h3001; CPU_CS = 1'b1;
        r1 = -1;
        r2 = -1;
        bl = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (r1 >= 0 && !BUSY) bl++;
            if (CPU_READY) begin
                if (r1 < 0) r1 = i;
                else r2 = i;
            end
            if (r2 >= 0) break;
        end
        CPU_CS = 1'b0;
        tick();
        tick();
        chk("hold_first", 16'(r1), 16'd3);
        chk("hold_gap", 16'(r2 - r1), 16'd4);
        chk("hold_idle", 16'(bl), 16'd1);
        chk("hold_end_busy", 16'(BUSY), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
